// File: rtl/fsm_memoria_resp_if.sv
// ---------------------------------------------------------------------------
// fsm_memoria_resp_if
// Bundle of the send/ack word-transfer handshake and the FIFO read port
// used by fsm_memoria_resp.
//   send    : 2-bit request code from the initiator (00 idle, 01 write)
//   dado    : DW-bit write data, valid while send==01
//   ack     : 2-bit response (00 none, 01 accepted, 10 error)
//   rd_en   : consumer pop request
//   rd_data : FIFO head word (first-word-fall-through)
//   empty   : FIFO empty flag
//   full    : FIFO full flag
//   count   : stored word count
//   err_cnt : saturating count of illegal requests
// Modports: slave (responder side), master (initiator / consumer side).
// ---------------------------------------------------------------------------
interface fsm_memoria_resp_if #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]    send;
   logic [DW-1:0] dado;
   logic [1:0]    ack;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic [7:0]    err_cnt;

   modport slave (
      input  send, dado, rd_en,
      output ack, rd_data, empty, full, count, err_cnt
   );

   modport master (
      output send, dado, rd_en,
      input  ack, rd_data, empty, full, count, err_cnt
   );
endinterface

// File: rtl/fsm_memoria_resp.sv
// ---------------------------------------------------------------------------
// fsm_memoria_resp
// Responder end of the send/ack word-transfer handshake. Accepted words are
// stored in a small circular FIFO that a downstream consumer drains through a
// first-word-fall-through read port. While the FIFO is full the request is
// held in STALL and ack is withheld (backpressure).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : fsm_memoria_resp_if.slave (send, dado, ack, rd_en, rd_data,
//          empty, full, count, err_cnt)
//
// Parameters:
//   DW       : data word width
//   DEPTH    : FIFO depth, power of two, >= 2
//   ACK_WAIT : extra wait cycles before ack when ACK_STALL_EN is defined
//
// Optional build macro ACK_STALL_EN: adds a WAIT state after each push that
// delays ack by ACK_WAIT cycles, modelling a slow memory.
// ---------------------------------------------------------------------------
module fsm_memoria_resp #(
   parameter int DW       = 16,
   parameter int DEPTH    = 4,
   parameter int ACK_WAIT = 2
) (
   input  logic                clk,
   input  logic                rst,
   fsm_memoria_resp_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fsm_memoria_resp: DEPTH must be a power of two >= 2");
   end
   if (ACK_WAIT < 1 || ACK_WAIT > 15) begin : g_bad_wait
      $error("fsm_memoria_resp: ACK_WAIT must be in 1..15");
   end

`ifdef ACK_STALL_EN
   typedef enum logic [2:0] {S_IDLE, S_STALL, S_ACK, S_NACK, S_WAIT} state_t;
   localparam state_t S_POST = S_WAIT;
`else
   typedef enum logic [2:0] {S_IDLE, S_STALL, S_ACK, S_NACK} state_t;
   localparam state_t S_POST = S_ACK;
`endif

   state_t         state_q, state_d;
   logic [1:0]     ack_q;
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [7:0]     err_q;
   logic [DW-1:0]  mem [DEPTH];

   logic full, empty, push, pop, req_wr, req_bad;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign req_wr  = (bus.send == 2'b01);
   assign req_bad = bus.send[1];
   assign pop     = bus.rd_en && !empty;

`ifdef ACK_STALL_EN
   logic [3:0] wcnt_q;
`endif

   function automatic logic [1:0] ack_decode(input state_t s);
      case (s)
         S_ACK:   ack_decode = 2'b01;
         S_NACK:  ack_decode = 2'b10;
         default: ack_decode = 2'b00;
      endcase
   endfunction

   // Next-state logic; full is the pre-pop value so a stalled request is
   // only accepted on the cycle after space frees.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_wr) begin
               if (!full) begin
                  push    = 1'b1;
                  state_d = S_POST;
               end else begin
                  state_d = S_STALL;
               end
            end else if (req_bad) begin
               state_d = S_NACK;
            end
         end
         S_STALL: begin
            if (req_wr && !full) begin
               push    = 1'b1;
               state_d = S_POST;
            end else if (req_bad) begin
               state_d = S_NACK;
            end else if (bus.send == 2'b00) begin
               state_d = S_IDLE;
            end
         end
         S_ACK, S_NACK: begin
            if (bus.send == 2'b00) state_d = S_IDLE;
         end
`ifdef ACK_STALL_EN
         // Leaving when the counter would reach zero lands the registered
         // ack exactly ACK_WAIT+1 cycles after the push edge.
         S_WAIT: begin
            if (wcnt_q <= 4'd1) state_d = S_ACK;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ack_q    <= 2'b00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= '0;
      end else begin
         state_q <= state_d;
         // ack follows the registered state, one cycle behind it
         ack_q   <= ack_decode(state_q);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (state_d == S_NACK && state_q != S_NACK && err_q != 8'hFF)
            err_q <= err_q + 1'b1;
      end
   end

`ifdef ACK_STALL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
      end else if (push) begin
         wcnt_q <= 4'(ACK_WAIT);
      end else if (state_q == S_WAIT && wcnt_q != 4'd0) begin
         wcnt_q <= wcnt_q - 1'b1;
      end
   end
`endif

   // Storage is not reset; contents are meaningless until pushed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.dado;
   end

   assign bus.ack     = ack_q;
   assign bus.rd_data = empty ? '0 : mem[rd_ptr_q];
   assign bus.empty   = empty;
   assign bus.full    = full;
   assign bus.count   = count_q;
   assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_fsm_memoria_resp.sv
module tb_fsm_memoria_resp;
   localparam int DW = 16;
   localparam int DEPTH = 4;
`ifdef ACK_STALL_EN
   localparam int ACK_LAT = 4;
`else
   localparam int ACK_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fsm_memoria_resp_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

   fsm_memoria_resp #(.DW(DW), .DEPTH(DEPTH), .ACK_WAIT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Full handshake: raise send, wait for ack=01, drop send, wait for ack=00.
   task automatic push_word(input logic [15:0] d, output bit ok);
      ok = 1'b0;
      bus.send = 2'b01;
      bus.dado = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.ack == 2'b01) ok = 1'b1;
      end
      bus.send = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.ack == 2'b00) break;
      end
   endtask

   task automatic pop_one();
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      bus.send = 2'b00; bus.dado = '0; bus.rd_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.ack !== 2'b00 || bus.count !== 3'd0 || bus.empty !== 1'b1 ||
          bus.full !== 1'b0 || bus.err_cnt !== 8'd0 || bus.rd_data !== 16'h0) begin
         fails++;
         $display("FAIL reset: ack=%b count=%0d empty=%b full=%b err=%0d rd=%h, want 00/0/1/0/0/0000",
                  bus.ack, bus.count, bus.empty, bus.full, bus.err_cnt, bus.rd_data);
      end
   endtask

   task automatic test_single();
      logic [1:0] exp_ack;
      bus.send = 2'b01; bus.dado = 16'hA5A5;
      @(negedge clk);
      tests++;
      if (bus.count !== 3'd1 || bus.rd_data !== 16'hA5A5 || bus.ack !== 2'b00) begin
         fails++;
         $display("FAIL single_capture: count=%0d rd=%h ack=%b, want 1/A5A5/00",
                  bus.count, bus.rd_data, bus.ack);
      end
      for (int k = 1; k <= ACK_LAT; k++) begin
         @(negedge clk);
         exp_ack = (k == ACK_LAT) ? 2'b01 : 2'b00;
         tests++;
         if (bus.ack !== exp_ack) begin
            fails++;
            $display("FAIL single_ack_lat%0d: ack=%b, want %b", k, bus.ack, exp_ack);
         end
      end
      bus.send = 2'b00;
      repeat (2) @(negedge clk);
      tests++;
      if (bus.ack !== 2'b00) begin
         fails++;
         $display("FAIL single_ack_drop: ack=%b, want 00", bus.ack);
      end
      pop_one();
      tests++;
      if (bus.empty !== 1'b1) begin
         fails++;
         $display("FAIL single_drain: empty=%b, want 1", bus.empty);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit ack_seen;
      logic [15:0] exp;
      for (int i = 1; i <= 4; i++) begin
         push_word(16'(i), ok);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL b2b_push%0d: no ack within budget, want ack=01", i);
         end
      end
      tests++;
      if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
         fails++;
         $display("FAIL b2b_full: full=%b count=%0d, want 1/4", bus.full, bus.count);
      end
      bus.send = 2'b01; bus.dado = 16'h0005;
      ack_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.ack !== 2'b00) ack_seen = 1'b1;
      end
      tests++;
      if (ack_seen || bus.rd_data !== 16'h0001) begin
         fails++;
         $display("FAIL b2b_stall: ack_seen=%b rd=%h, want 0/0001", ack_seen, bus.rd_data);
      end
      pop_one();
      tests++;
      if (bus.rd_data !== 16'h0002 || bus.count !== 3'd3 || bus.ack !== 2'b00) begin
         fails++;
         $display("FAIL b2b_pop: rd=%h count=%0d ack=%b, want 0002/3/00",
                  bus.rd_data, bus.count, bus.ack);
      end
      @(negedge clk);
      tests++;
      if (bus.count !== 3'd4) begin
         fails++;
         $display("FAIL b2b_accept: count=%0d, want 4", bus.count);
      end
      repeat (ACK_LAT) @(negedge clk);
      tests++;
      if (bus.ack !== 2'b01) begin
         fails++;
         $display("FAIL b2b_ack: ack=%b, want 01", bus.ack);
      end
      bus.send = 2'b00;
      repeat (2) @(negedge clk);
      for (int i = 2; i <= 5; i++) begin
         exp = 16'(i);
         tests++;
         if (bus.rd_data !== exp) begin
            fails++;
            $display("FAIL b2b_order%0d: rd=%h, want %h", i, bus.rd_data, exp);
         end
         pop_one();
      end
      tests++;
      if (bus.empty !== 1'b1) begin
         fails++;
         $display("FAIL b2b_empty: empty=%b, want 1", bus.empty);
      end
   endtask

   task automatic test_nack();
      bus.send = 2'b10;
      @(negedge clk);
      tests++;
      if (bus.err_cnt !== 8'd1 || bus.count !== 3'd0) begin
         fails++;
         $display("FAIL nack_err: err=%0d count=%0d, want 1/0", bus.err_cnt, bus.count);
      end
      @(negedge clk);
      tests++;
      if (bus.ack !== 2'b10) begin
         fails++;
         $display("FAIL nack_ack: ack=%b, want 10", bus.ack);
      end
      bus.send = 2'b00;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 255; i++) begin
         bus.send = (i[0]) ? 2'b11 : 2'b10;
         @(negedge clk);
         bus.send = 2'b00;
         @(negedge clk);
      end
      tests++;
      if (bus.err_cnt !== 8'd255 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
         fails++;
         $display("FAIL nack_saturate: err=%0d count=%0d empty=%b, want 255/0/1",
                  bus.err_cnt, bus.count, bus.empty);
      end
      @(negedge clk);
   endtask

   task automatic test_empty_read();
      pop_one();
      tests++;
      if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.rd_data !== 16'h0) begin
         fails++;
         $display("FAIL empty_read: count=%0d empty=%b rd=%h, want 0/1/0000",
                  bus.count, bus.empty, bus.rd_data);
      end
   endtask

   task automatic test_push_pop();
      bit ok;
      push_word(16'h0011, ok);
      push_word(16'h0022, ok);
      tests++;
      if (bus.count !== 3'd2) begin
         fails++;
         $display("FAIL pp_setup: count=%0d, want 2", bus.count);
      end
      bus.send = 2'b01; bus.dado = 16'h0033; bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      tests++;
      if (bus.count !== 3'd2 || bus.rd_data !== 16'h0022) begin
         fails++;
         $display("FAIL pp_same_cycle: count=%0d rd=%h, want 2/0022", bus.count, bus.rd_data);
      end
      repeat (ACK_LAT) @(negedge clk);
      bus.send = 2'b00;
      repeat (2) @(negedge clk);
      pop_one();
      tests++;
      if (bus.rd_data !== 16'h0033 || bus.count !== 3'd1) begin
         fails++;
         $display("FAIL pp_order: rd=%h count=%0d, want 0033/1", bus.rd_data, bus.count);
      end
      pop_one();
   endtask

   task automatic test_stall_abort();
      bit ok;
      bit ack_seen;
      for (int i = 0; i < 4; i++) push_word(16'h0041 + 16'(i), ok);
      bus.send = 2'b01; bus.dado = 16'h0077;
      ack_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.ack !== 2'b00) ack_seen = 1'b1;
      end
      bus.send = 2'b00;
      repeat (3) begin
         @(negedge clk);
         if (bus.ack !== 2'b00) ack_seen = 1'b1;
      end
      tests++;
      if (ack_seen || bus.count !== 3'd4) begin
         fails++;
         $display("FAIL stall_abort: ack_seen=%b count=%0d, want 0/4", ack_seen, bus.count);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (bus.rd_data !== 16'h0041 + 16'(i)) begin
            fails++;
            $display("FAIL stall_abort_data%0d: rd=%h, want %h", i, bus.rd_data, 16'h0041 + 16'(i));
         end
         pop_one();
      end
      tests++;
      if (bus.empty !== 1'b1) begin
         fails++;
         $display("FAIL stall_abort_empty: empty=%b, want 1", bus.empty);
      end
   endtask

   task automatic test_reset_mid_ack();
      bus.send = 2'b01; bus.dado = 16'h0099;
      repeat (ACK_LAT + 1) @(negedge clk);
      tests++;
      if (bus.ack !== 2'b01) begin
         fails++;
         $display("FAIL rst_mid_pre: ack=%b, want 01", bus.ack);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.ack !== 2'b00 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_ack: ack=%b count=%0d empty=%b, want 00/0/1",
                  bus.ack, bus.count, bus.empty);
      end
      rst = 1'b0;
      bus.send = 2'b00;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_nack();
      test_empty_read();
      test_push_pop();
      test_stall_abort();
      test_reset_mid_ack();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
